aabb_hit_scheduler: RTL and testbench
=====================================

AABB_HIT_SCHEDULER -- requirements
Module: aabb_hit_scheduler

Interface
REQ-001 SHALL have one clock `clk` and a synchronous, active-high reset `reset`; every register samples on the rising edge of `clk`.
REQ-002 SHALL declare ports as follows:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  ray request valid
- start_ready  out  1  scheduler can accept a ray
- ray  in  Ray  ray to test (Orig, InvDir, Dir, MinT, MaxT, PI)
- any_hit  in  1  terminate on first accepted hit
- num_prims  in  `PRIMITIVE_INDEX  count of AABBs to test (0 allowed)
- prim_rd_en  out  1  primitive memory read strobe
- prim_addr  out  `PRIMITIVE_INDEX  primitive memory address
- prim_aabb  in  AABB  read data, valid 1 cycle after prim_rd_en
- prim_color  in  RGB8  read data, same timing as prim_aabb
- prim_st  in  SurfaceType  read data, same timing as prim_aabb
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_hit  out  HitData  closest (or first) hit
- busy  out  1  high in any state other than IDLE

Function
REQ-003 SHALL be a 4-state FSM: IDLE, ISSUE, DRAIN, DONE.
REQ-004 start_ready SHALL equal (state==IDLE); accept = start_valid && start_ready.
REQ-005 On accept, SHALL latch ray, any_hit and num_prims; inputs after that cycle SHALL NOT affect the job.
REQ-006 IDLE->ISSUE on accept when num_prims!=0; IDLE->DONE on accept when num_prims==0.
REQ-007 In ISSUE, SHALL assert prim_rd_en every cycle with prim_addr = 0,1,...,num_prims-1 (one address per cycle, no bubbles); ISSUE->DRAIN after issuing address num_prims-1.
REQ-008 SHALL run each returned AABB through one AABBHit instance using the latched ray and pi = address issued one cycle earlier, then register that result into stage register S (valid bit + HitData).
REQ-009 Merge rule: when S.valid && S.bHit && (!best.bHit || S.T < best.T), best SHALL take S; on equal T the lower index (earlier result) SHALL be kept.
REQ-010 DRAIN->DONE once the last in-flight result has been merged.
REQ-011 Latency: for N>=1 prims, out_valid SHALL rise exactly N+3 cycles after the accept cycle; for N=0, exactly 1 cycle after it.
REQ-012 Any-hit mode: on the first S.bHit, best SHALL take S, prim_rd_en SHALL deassert from the next cycle, in-flight results SHALL be discarded, and the FSM SHALL go to DONE.
REQ-013 In DONE, out_valid=1 and out_hit=best; out_hit SHALL remain stable until out_valid && out_ready, then the FSM SHALL go to IDLE; start_ready SHALL NOT assert in the same cycle as that handshake.
REQ-014 No-hit result: out_hit.bHit=0, out_hit.PI=`NULL_PRIMITIVE_INDEX, all other fields zero.
REQ-015 When latched ray.PI equals an address, that primitive SHALL NOT produce a hit (self-intersection exclusion by AABBHit).

Reset
REQ-016 On reset, state=IDLE; start_ready=0 during the reset cycle and 1 after; prim_rd_en=0, prim_addr=0, out_valid=0, busy=0, S.valid=0, best = no-hit value.
REQ-017 Reset asserted mid-job (ISSUE/DRAIN/DONE) SHALL abort the job with no out_valid pulse, and the in-flight read data SHALL be ignored.

Structure
REQ-018 Ray, AABB, HitData, RGB8, SurfaceType, `PRIMITIVE_INDEX and the FSM state enum SHALL come from the shared Types package.
REQ-019 SHALL instantiate exactly one AABBHit as its only sub-module; T comparison SHALL use Fixed_Less.

Verification
REQ-020 num_prims=0, accept at cycle 0 -> out_valid at cycle 1, bHit=0, PI=NULL, no prim_rd_en.
REQ-021 Ray Orig=(0,0,-10), Dir=(0,0,1); 3 boxes at z=[5,6], [-2,-1], [0,1]; closest mode -> PI=2, T=10.0, Normal=(0,0,-1), out_valid at cycle 6.
REQ-022 Same scene, any_hit=1 -> PI=0 returned at cycle 4, only addresses 0,1,2 issued.
REQ-023 Two identical boxes at indices 1 and 3 -> PI=1 (tie keeps lower index).
REQ-024 Hold out_ready=0 for 5 cycles in DONE -> out_hit stable, start_ready=0 throughout; accept occurs on the first out_ready=1.
REQ-025 Assert reset at cycle 3 of a 10-prim job -> prim_rd_en=0 from the next cycle, no out_valid, new job accepted normally afterwards.

Source files
------------

// File: rtl/aabb_hit_scheduler_pkg.sv
// Shared types for the AABB hit scheduler: Q16.16 fixed point, ray/box/hit
// records, the scheduler state enum and small fixed-point helpers.
package aabb_hit_scheduler_pkg;

    localparam int PI_W = 8;
    typedef logic [PI_W-1:0] prim_index_t;
    // All-ones is never a valid address because num_prims tops out at 2^PI_W-1.
    localparam prim_index_t NULL_PRIMITIVE_INDEX = '1;

    typedef logic signed [31:0] fixed_t;
    localparam fixed_t FX_ONE     = 32'sh0001_0000;
    localparam fixed_t FX_NEG_ONE = -32'sh0001_0000;

    // Element 0 = x, 1 = y, 2 = z.
    typedef logic [2:0][31:0] vec3_t;

    typedef struct packed {
        vec3_t       orig;
        vec3_t       inv_dir;
        vec3_t       dir;
        fixed_t      min_t;
        fixed_t      max_t;
        prim_index_t pi;
    } ray_t;

    typedef struct packed {
        vec3_t lo;
        vec3_t hi;
    } aabb_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef enum logic [1:0] {
        SURF_DIFFUSE,
        SURF_MIRROR,
        SURF_GLASS,
        SURF_EMISSIVE
    } surface_t;

    typedef struct packed {
        logic        hit;
        fixed_t      t;
        vec3_t       normal;
        prim_index_t pi;
        rgb8_t       color;
        surface_t    st;
    } hit_data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam hit_data_t NO_HIT = '{hit: 1'b0, t: '0, normal: '0,
                                     pi: NULL_PRIMITIVE_INDEX, color: '0,
                                     st: SURF_DIFFUSE};

    // Signed fixed-point ordering used for every T comparison.
    function automatic logic fixed_less(input fixed_t a, input fixed_t b);
        return a < b;
    endfunction

    // Q16.16 multiply that saturates; infinite inverse directions are
    // encoded as the largest representable value and must not wrap.
    function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = a;
        sb = b;
        p  = (sa * sb) >>> 16;
        if (p > 64'sh0000_0000_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        if (p < -64'sh0000_0000_8000_0000)
            return -32'sh8000_0000;
        return fixed_t'(p[31:0]);
    endfunction

endpackage

// File: rtl/aabb_hit_scheduler_aabb_hit.sv
// Combinational slab test of one ray against one AABB; produces a full
// hit record (entry T, entry-face normal, primitive attributes).
module aabb_hit
    import aabb_hit_scheduler_pkg::*;
(
    input  ray_t        ray,
    input  aabb_t       box,
    input  prim_index_t pi,
    input  rgb8_t       color,
    input  surface_t    st,
    output hit_data_t   result
);

    fixed_t     slab_lo   [3];
    fixed_t     slab_hi   [3];
    fixed_t     slab_near [3];
    fixed_t     slab_far  [3];
    fixed_t     t_enter;
    fixed_t     t_exit;
    logic [1:0] axis;
    logic       hit;

    // Per-axis entry/exit distances, then the overall interval and face.
    always_comb begin
        for (int a = 0; a < 3; a++) begin
            slab_lo[a]   = fx_mul(box.lo[a] - ray.orig[a], ray.inv_dir[a]);
            slab_hi[a]   = fx_mul(box.hi[a] - ray.orig[a], ray.inv_dir[a]);
            slab_near[a] = fixed_less(slab_lo[a], slab_hi[a]) ? slab_lo[a] : slab_hi[a];
            slab_far[a]  = fixed_less(slab_lo[a], slab_hi[a]) ? slab_hi[a] : slab_lo[a];
        end

        // The latest entering slab is the face we cross.
        t_enter = slab_near[0];
        axis    = 2'd0;
        if (fixed_less(t_enter, slab_near[1])) begin
            t_enter = slab_near[1];
            axis    = 2'd1;
        end
        if (fixed_less(t_enter, slab_near[2])) begin
            t_enter = slab_near[2];
            axis    = 2'd2;
        end
        if (fixed_less(t_enter, ray.min_t))
            t_enter = ray.min_t;

        t_exit = ray.max_t;
        for (int a = 0; a < 3; a++)
            if (fixed_less(slab_far[a], t_exit))
                t_exit = slab_far[a];

        // A ray leaving a surface must not re-hit the primitive it left.
        hit = !fixed_less(t_exit, t_enter) && (pi != ray.pi);

        result = NO_HIT;
        if (hit) begin
            result.hit          = 1'b1;
            result.t            = t_enter;
            result.normal[axis] = ray.dir[axis][31] ? FX_ONE : FX_NEG_ONE;
            result.pi           = pi;
            result.color        = color;
            result.st           = st;
        end
    end

endmodule

// File: rtl/aabb_hit_scheduler.sv
// Streams num_prims AABBs from primitive memory through one slab tester and
// keeps the closest (or, in any-hit mode, the first) hit for the latched ray.
module aabb_hit_scheduler
    import aabb_hit_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  ray_t        ray,
    input  logic        any_hit,
    input  prim_index_t num_prims,
    output logic        prim_rd_en,
    output prim_index_t prim_addr,
    input  aabb_t       prim_aabb,
    input  rgb8_t       prim_color,
    input  surface_t    prim_st,
    output logic        out_valid,
    input  logic        out_ready,
    output hit_data_t   out_hit,
    output logic        busy
);

    state_t      state;
    state_t      state_n;
    ray_t        ray_q;
    logic        any_hit_q;
    prim_index_t num_q;
    prim_index_t addr_q;
    logic        rd_vld_q;   // read data for rd_pi_q is on the bus this cycle
    prim_index_t rd_pi_q;
    logic        s_vld;      // stage register S
    hit_data_t   s_hit;
    hit_data_t   best;
    hit_data_t   cand;
    logic        accept;
    logic        in_job;
    logic        take_s;
    logic        early_stop;
    logic        last_addr;

    assign accept     = start_valid && start_ready;
    assign in_job     = (state == ST_ISSUE) || (state == ST_DRAIN);
    // Strict less-than keeps the earlier (lower index) result on a tie.
    assign take_s     = in_job && s_vld && s_hit.hit &&
                        (!best.hit || fixed_less(s_hit.t, best.t));
    assign early_stop = in_job && any_hit_q && s_vld && s_hit.hit;
    assign last_addr  = (addr_q == num_q - prim_index_t'(1));
    assign out_hit    = best;

    aabb_hit u_aabb_hit (
        .ray    (ray_q),
        .box    (prim_aabb),
        .pi     (rd_pi_q),
        .color  (prim_color),
        .st     (prim_st),
        .result (cand)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next state and handshake/strobe outputs; all outputs quiet during reset.
    always_comb begin
        state_n     = state;
        start_ready = 1'b0;
        prim_rd_en  = 1'b0;
        prim_addr   = '0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                busy        = 1'b0;
                start_ready = !reset;
                if (start_valid && !reset)
                    state_n = (num_prims != '0) ? ST_ISSUE : ST_DONE;
            end
            ST_ISSUE: begin
                prim_rd_en = !reset;
                prim_addr  = addr_q;
                if (early_stop)
                    state_n = ST_DONE;
                else if (last_addr)
                    state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Nothing left on the read bus: S holds the final result.
                if (early_stop || !rd_vld_q)
                    state_n = ST_DONE;
            end
            ST_DONE: begin
                out_valid = !reset;
                if (out_ready)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Job context: latched request, address counter and running best hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ray_q     <= '0;
            any_hit_q <= 1'b0;
            num_q     <= '0;
            addr_q    <= '0;
            best      <= NO_HIT;
        end else if (accept) begin
            ray_q     <= ray;
            any_hit_q <= any_hit;
            num_q     <= num_prims;
            addr_q    <= '0;
            best      <= NO_HIT;
        end else begin
            if (prim_rd_en)
                addr_q <= addr_q + prim_index_t'(1);
            if (take_s)
                best <= s_hit;
        end
    end

    // Read-return tracking and stage register S; an any-hit stop kills
    // everything still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            rd_pi_q  <= '0;
            s_vld    <= 1'b0;
            s_hit    <= NO_HIT;
        end else begin
            rd_vld_q <= prim_rd_en && !early_stop;
            rd_pi_q  <= prim_addr;
            s_vld    <= rd_vld_q && in_job && !early_stop;
            s_hit    <= cand;
        end
    end

endmodule

// File: tb/tb_aabb_hit_scheduler.sv
// Scoreboard bench: the driver pushes the reference result of each job, a
// negedge monitor checks latency, issued addresses and the held result.
module tb_aabb_hit_scheduler;
    import aabb_hit_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    ray_t        ray = '0;
    logic        any_hit = 1'b0;
    prim_index_t num_prims = '0;
    logic        prim_rd_en;
    prim_index_t prim_addr;
    aabb_t       prim_aabb = '0;
    rgb8_t       prim_color = '0;
    surface_t    prim_st = SURF_DIFFUSE;
    logic        out_valid;
    logic        out_ready = 1'b0;
    hit_data_t   out_hit;
    logic        busy;

    aabb_hit_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .ray        (ray),
        .any_hit    (any_hit),
        .num_prims  (num_prims),
        .prim_rd_en (prim_rd_en),
        .prim_addr  (prim_addr),
        .prim_aabb  (prim_aabb),
        .prim_color (prim_color),
        .prim_st    (prim_st),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hit    (out_hit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        hit_data_t hit;
        int        lat;
        int        issues;
    } exp_t;

    exp_t      exp_q[$];
    int        vectors = 0;
    int        miscompares = 0;
    int        cyc = 0;

    aabb_t     mem_box [256];
    rgb8_t     mem_col [256];
    surface_t  mem_st  [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Primitive memory: one-cycle read latency.
    always @(posedge clk)
        if (prim_rd_en) begin
            prim_aabb  <= mem_box[prim_addr];
            prim_color <= mem_col[prim_addr];
            prim_st    <= mem_st[prim_addr];
        end

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_hit(input string name, input hit_data_t act, input hit_data_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic fixed_t fx(input int v);
        return fixed_t'(v * 65536);
    endfunction

    function automatic hit_data_t mk_hit(input int i, input int t);
        hit_data_t h;
        h           = NO_HIT;
        h.hit       = 1'b1;
        h.t         = fx(t);
        h.normal    = '0;
        h.normal[2] = 32'hFFFF_0000;
        h.pi        = prim_index_t'(i);
        h.color     = mem_col[i];
        h.st        = mem_st[i];
        return h;
    endfunction

    // Ray travelling +z; x/y direction components are zero (infinite inverse).
    function automatic ray_t mk_ray(input fixed_t ox, input fixed_t oy, input int oz,
                                    input int maxt, input prim_index_t rpi);
        ray_t r;
        r            = '0;
        r.orig[0]    = ox;
        r.orig[1]    = oy;
        r.orig[2]    = fx(oz);
        r.inv_dir[0] = 32'h7FFF_FFFF;
        r.inv_dir[1] = 32'h7FFF_FFFF;
        r.inv_dir[2] = 32'h0001_0000;
        r.dir[2]     = 32'h0001_0000;
        r.min_t      = '0;
        r.max_t      = fx(maxt);
        r.pi         = rpi;
        return r;
    endfunction

    task automatic load_box(input int i, input int lx, input int hx, input int ly,
                            input int hy, input int lz, input int hz);
        mem_box[i].lo[0] = fx(lx);
        mem_box[i].hi[0] = fx(hx);
        mem_box[i].lo[1] = fx(ly);
        mem_box[i].hi[1] = fx(hy);
        mem_box[i].lo[2] = fx(lz);
        mem_box[i].hi[2] = fx(hz);
        mem_col[i]       = rgb8_t'(24'($urandom));
        mem_st[i]        = surface_t'(2'($urandom_range(0, 3)));
    endtask

    // Monitor: accept cycle, address sequence, result on rise and while held.
    int        acc_cyc = 0;
    int        issued = 0;
    logic      prev_ov = 1'b0;
    logic      cur_ok = 1'b0;
    exp_t      cur;

    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
            cur_ok  = 1'b0;
        end else begin
            if (start_valid && start_ready) begin
                acc_cyc = cyc;
                issued  = 0;
            end
            if (prim_rd_en) begin
                chk_int("prim_addr", int'(prim_addr), issued);
                issued++;
            end
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    cur_ok = 1'b0;
                    chk_int("unexpected_out_valid", 1, 0);
                end else begin
                    cur    = exp_q[0];
                    cur_ok = 1'b1;
                    chk_int("latency", cyc - acc_cyc, cur.lat);
                    chk_hit("out_hit", out_hit, cur.hit);
                    chk_int("issued_count", issued, cur.issues);
                end
            end else if (out_valid && cur_ok) begin
                chk_hit("out_hit_stable", out_hit, cur.hit);
            end
            if (out_valid)
                chk_int("start_ready_in_done", int'(start_ready), 0);
            if (out_valid && out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            prev_ov = out_valid;
        end
    end

    // Offer a job, scramble inputs after accept, then hold off out_ready.
    task automatic run_job(input ray_t r, input logic any, input int n,
                           input exp_t e, input int hold);
        int   guard;
        ray_t junk;
        @(posedge clk); #1;
        ray         = r;
        any_hit     = any;
        num_prims   = prim_index_t'(n);
        start_valid = 1'b1;
        exp_q.push_back(e);
        guard = 0;
        forever begin
            @(negedge clk);
            if (start_ready) break;
            guard++;
            if (guard > 200) begin
                chk_int("accept_timeout", 0, 1);
                start_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        start_valid = 1'b0;
        junk        = r;
        junk.orig[2] = $urandom;
        junk.pi      = prim_index_t'($urandom);
        junk.max_t   = fixed_t'($urandom);
        ray          = junk;
        any_hit      = ~any;
        num_prims    = prim_index_t'($urandom);
        guard = 0;
        while (!out_valid && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) begin
            chk_int("out_valid_timeout", 0, 1);
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_int("idle_after_handshake", int'({out_valid, busy, start_ready}), 1);
    endtask

    task automatic scene_a();
        load_box(0, -1, 1, -1, 1, 5, 6);
        load_box(1, 2, 3, -1, 1, -2, -1);
        load_box(2, -1, 1, -1, 1, 0, 1);
    endtask

    // Random job on a +z ray through (0.5, 0.5, oz), integer-aligned boxes.
    task automatic rand_job();
        int   n, oz, maxt, rpi, pick, first_i, best_i, best_t, t, tf;
        logic any;
        int   lo [16][3];
        int   hi [16][3];
        exp_t e;
        n    = $urandom_range(0, 12);
        oz   = int'($urandom_range(0, 10)) - 5;
        maxt = $urandom_range(5, 30);
        any  = 1'($urandom_range(0, 1));
        rpi  = 255;
        if (n > 0 && $urandom_range(0, 2) == 0)
            rpi = $urandom_range(0, n - 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                pick  = $urandom_range(0, i - 1);
                lo[i] = lo[pick];
                hi[i] = hi[pick];
            end else begin
                for (int a = 0; a < 2; a++) begin
                    lo[i][a] = int'($urandom_range(0, 5)) - 3;
                    hi[i][a] = lo[i][a] + int'($urandom_range(1, 3));
                end
                lo[i][2] = int'($urandom_range(0, 25)) - 5;
                hi[i][2] = lo[i][2] + int'($urandom_range(0, 3));
            end
            load_box(i, lo[i][0], hi[i][0], lo[i][1], hi[i][1], lo[i][2], hi[i][2]);
        end
        // Hit when the footprint covers (0.5,0.5) and the z span meets [oz, oz+maxt].
        first_i = -1;
        best_i  = -1;
        best_t  = 0;
        for (int i = 0; i < n; i++) begin
            t  = (lo[i][2] - oz > 0) ? lo[i][2] - oz : 0;
            tf = (hi[i][2] - oz < maxt) ? hi[i][2] - oz : maxt;
            if (lo[i][0] <= 0 && hi[i][0] >= 1 && lo[i][1] <= 0 && hi[i][1] >= 1 &&
                t <= tf && i != rpi) begin
                if (first_i < 0) first_i = i;
                if (best_i < 0 || t < best_t) begin
                    best_i = i;
                    best_t = t;
                end
            end
        end
        if (any && first_i >= 0) begin
            t        = (lo[first_i][2] - oz > 0) ? lo[first_i][2] - oz : 0;
            e.hit    = mk_hit(first_i, t);
            e.lat    = first_i + 4;
            e.issues = (first_i + 3 < n) ? first_i + 3 : n;
        end else begin
            e.hit    = (best_i < 0) ? NO_HIT : mk_hit(best_i, best_t);
            e.lat    = (n == 0) ? 1 : n + 3;
            e.issues = n;
        end
        run_job(mk_ray(32'h0000_8000, 32'h0000_8000, oz, maxt, prim_index_t'(rpi)),
                any, n, e, $urandom_range(0, 3));
    endtask

    initial begin
        exp_t e;
        ray_t ra;
        int   guard;

        // Reset behaviour.
        @(negedge clk);
        chk_int("start_ready_in_reset", int'(start_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_int("rst_start_ready", int'(start_ready), 1);
        chk_int("rst_prim_rd_en", int'(prim_rd_en), 0);
        chk_int("rst_prim_addr", int'(prim_addr), 0);
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_hit("rst_out_hit", out_hit, NO_HIT);

        ra = mk_ray('0, '0, -10, 100, NULL_PRIMITIVE_INDEX);

        // Empty job.
        e.hit = NO_HIT; e.lat = 1; e.issues = 0;
        run_job(ra, 1'b0, 0, e, 1);

        // Closest hit with a 5-cycle consumer stall.
        scene_a();
        e.hit = mk_hit(2, 10); e.lat = 6; e.issues = 3;
        run_job(ra, 1'b0, 3, e, 5);

        // Any-hit stops on the first hit.
        e.hit = mk_hit(0, 15); e.lat = 4; e.issues = 3;
        run_job(ra, 1'b1, 3, e, 0);

        // Self-intersection exclusion.
        e.hit = mk_hit(0, 15); e.lat = 6; e.issues = 3;
        run_job(mk_ray('0, '0, -10, 100, prim_index_t'(2)), 1'b0, 3, e, 2);

        // Equal T keeps the lower index.
        load_box(0, 2, 3, -1, 1, 3, 4);
        load_box(1, -1, 1, -1, 1, 3, 4);
        load_box(2, 2, 3, -1, 1, 3, 4);
        load_box(3, -1, 1, -1, 1, 3, 4);
        load_box(4, 2, 3, -1, 1, 3, 4);
        e.hit = mk_hit(1, 13); e.lat = 8; e.issues = 5;
        run_job(ra, 1'b0, 5, e, 0);

        // Reset in the middle of a 10-prim job.
        for (int i = 0; i < 10; i++) load_box(i, -1, 1, -1, 1, i, i + 1);
        @(posedge clk); #1;
        ray = ra; any_hit = 1'b0; num_prims = prim_index_t'(10); start_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (start_ready || guard > 200) break;
            guard++;
        end
        chk_int("midrst_accept", int'(start_ready), 1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk_int("midrst_prim_rd_en", int'(prim_rd_en), 0);
            chk_int("midrst_out_valid", int'(out_valid), 0);
            chk_int("midrst_busy", int'(busy), 0);
        end

        // Normal job after the abort.
        scene_a();
        e.hit = mk_hit(2, 10); e.lat = 6; e.issues = 3;
        run_job(ra, 1'b0, 3, e, 0);

        repeat (60) rand_job();

        repeat (4) @(posedge clk);
        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
